// File: rtl/traffic_light_multi_phase_if.sv
// Bundle of request inputs and lamp/status outputs for the multi-phase traffic light.
interface traffic_light_multi_phase_if #(
    parameter int NUM_PHASES = 2,
    parameter int PW         = $clog2(NUM_PHASES)
);
    logic [NUM_PHASES-1:0]   ped_req;
    logic                    emerg_req;
    logic [PW-1:0]           emerg_phase;
    logic                    flash_mode;
    logic [3*NUM_PHASES-1:0] lights;
    logic [NUM_PHASES-1:0]   ped_walk;
    logic [PW-1:0]           phase_idx;
    logic [2:0]              state;

    modport master (
        output ped_req, emerg_req, emerg_phase, flash_mode,
        input  lights, ped_walk, phase_idx, state
    );

    modport slave (
        input  ped_req, emerg_req, emerg_phase, flash_mode,
        output lights, ped_walk, phase_idx, state
    );
endinterface

// File: rtl/traffic_light_multi_phase.sv
// Round-robin multi-approach traffic light with pedestrian extension, emergency
// pre-emption and all-red flashing; every output is a register.
module traffic_light_multi_phase #(
    parameter int NUM_PHASES       = 2,
    parameter int CNT_W            = 8,
    parameter int GREEN_CYCLES     = 20,
    parameter int PED_EXTRA_CYCLES = 8,
    parameter int YELLOW_CYCLES    = 4,
    parameter int ALL_RED_CYCLES   = 2,
    parameter int FLASH_CYCLES     = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    traffic_light_multi_phase_if.slave bus
);
    localparam int PW = $clog2(NUM_PHASES);

    localparam logic [2:0] ST_ALL_RED = 3'd0;
    localparam logic [2:0] ST_GREEN   = 3'd1;
    localparam logic [2:0] ST_YELLOW  = 3'd2;
    localparam logic [2:0] ST_FLASH   = 3'd3;
    localparam logic [2:0] ST_PREEMPT = 3'd4;

    localparam logic [CNT_W-1:0] LD_GREEN     = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_GREEN_PED = CNT_W'(GREEN_CYCLES + PED_EXTRA_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW    = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_ALL_RED   = CNT_W'(ALL_RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_FLASH     = CNT_W'(FLASH_CYCLES - 1);

    logic [2:0]              st, st_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [PW-1:0]           ph, ph_n, ph_inc, ep;
    logic [NUM_PHASES-1:0]   pend, pend_n, walk, walk_n, onehot;
    logic                    preempt, preempt_n;
    logic                    flash_on, flash_on_n;
    logic [3*NUM_PHASES-1:0] lights, lights_n;
    logic                    expired;

    function automatic logic [3*NUM_PHASES-1:0] lamp_map(input logic [2:0] s,
                                                         input logic [PW-1:0] p,
                                                         input logic fl);
        logic [3*NUM_PHASES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (s == ST_FLASH)
                v[3*i +: 3] = {fl, 2'b00};
            else if (PW'(i) == p && (s == ST_GREEN || s == ST_PREEMPT))
                v[3*i +: 3] = 3'b001;
            else if (PW'(i) == p && s == ST_YELLOW)
                v[3*i +: 3] = 3'b010;
            else
                v[3*i +: 3] = 3'b100;
        end
        return v;
    endfunction

    // Out-of-range emergency phases fall back to phase 0.
    assign ep      = ({1'b0, bus.emerg_phase} < (PW+1)'(NUM_PHASES)) ? bus.emerg_phase : '0;
    assign ph_inc  = (ph == PW'(NUM_PHASES - 1)) ? '0 : ph + 1'b1;
    assign onehot  = NUM_PHASES'(1) << ph_inc;
    assign expired = (cnt == '0);

    always_comb begin
        st_n       = st;
        cnt_n      = cnt - 1'b1;
        ph_n       = ph;
        pend_n     = pend | bus.ped_req;
        walk_n     = walk;
        preempt_n  = preempt;
        flash_on_n = flash_on;
        case (st)
            ST_ALL_RED: begin
                preempt_n = bus.emerg_req;
                if (expired) begin
                    if (preempt && bus.emerg_req) begin
                        st_n      = ST_PREEMPT;
                        ph_n      = ep;
                        cnt_n     = '0;
                        preempt_n = 1'b0;
                    end else if (bus.flash_mode) begin
                        st_n       = ST_FLASH;
                        cnt_n      = LD_FLASH;
                        flash_on_n = 1'b1;
                    end else begin
                        st_n   = ST_GREEN;
                        ph_n   = ph_inc;
                        cnt_n  = pend[ph_inc] ? LD_GREEN_PED : LD_GREEN;
                        walk_n = pend[ph_inc] ? onehot : '0;
                        // A request arriving on the serving edge survives for the next service.
                        pend_n = (pend & ~onehot) | bus.ped_req;
                    end
                end
            end
            ST_GREEN: begin
                if (bus.emerg_req && ep == ph) begin
                    st_n      = ST_PREEMPT;
                    cnt_n     = '0;
                    walk_n    = '0;
                    preempt_n = 1'b0;
                end else if (bus.emerg_req) begin
                    st_n      = ST_YELLOW;
                    cnt_n     = LD_YELLOW;
                    walk_n    = '0;
                    preempt_n = 1'b1;
                end else begin
                    preempt_n = 1'b0;
                    if (expired) begin
                        st_n   = ST_YELLOW;
                        cnt_n  = LD_YELLOW;
                        walk_n = '0;
                    end
                end
            end
            ST_YELLOW: begin
                preempt_n = bus.emerg_req;
                if (expired) begin
                    st_n  = ST_ALL_RED;
                    cnt_n = LD_ALL_RED;
                end
            end
            ST_FLASH: begin
                preempt_n = 1'b0;
                if (!bus.flash_mode) begin
                    st_n  = ST_ALL_RED;
                    cnt_n = LD_ALL_RED;
                end else if (expired) begin
                    cnt_n      = LD_FLASH;
                    flash_on_n = ~flash_on;
                end
            end
            ST_PREEMPT: begin
                preempt_n = 1'b0;
                cnt_n     = cnt;
                if (!bus.emerg_req) begin
                    st_n  = ST_YELLOW;
                    cnt_n = LD_YELLOW;
                end
            end
            default: begin
                st_n  = ST_ALL_RED;
                cnt_n = LD_ALL_RED;
            end
        endcase
        lights_n = lamp_map(st_n, ph_n, flash_on_n);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= ST_ALL_RED;
            cnt      <= LD_ALL_RED;
            ph       <= PW'(NUM_PHASES - 1);
            pend     <= '0;
            preempt  <= 1'b0;
            flash_on <= 1'b1;
            walk     <= '0;
            lights   <= {NUM_PHASES{3'b100}};
        end else begin
            st       <= st_n;
            cnt      <= cnt_n;
            ph       <= ph_n;
            pend     <= pend_n;
            preempt  <= preempt_n;
            flash_on <= flash_on_n;
            walk     <= walk_n;
            lights   <= lights_n;
        end
    end

    assign bus.lights    = lights;
    assign bus.ped_walk  = walk;
    assign bus.phase_idx = ph;
    assign bus.state     = st;
endmodule

// File: doc/traffic_light_multi_phase.md
# traffic_light_multi_phase

Parametrised successor to the single-approach traffic light controller. Sequences NUM_PHASES approaches through green, yellow and all-red intervals in round-robin order. Adds latched pedestrian requests with green extension, emergency pre-emption of a selected phase, and an all-red flashing mode. It is a standalone block with fully registered lamp outputs that drive per-approach lamp triplets.

## Interface
- NUM_PHASES, 2: number of approaches (≥2).
- CNT_W, 8: interval counter width. Every duration parameter must be ≤ 2^CNT_W.
- GREEN_CYCLES, 20: base green duration (≥1).
- PED_EXTRA_CYCLES, 8: green extension when a pedestrian request is served (≥0).
- YELLOW_CYCLES, 4: yellow duration (≥1).
- ALL_RED_CYCLES, 2: all-red clearance duration (≥1).
- FLASH_CYCLES, 5: half-period of the flash toggle (≥1).
- PW (derived): $clog2(NUM_PHASES).

Ports:
- clk  in  1: sole clock, rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- ped_req  in  NUM_PHASES: pedestrian request pulses, one bit per phase. Latched.
- emerg_req  in  1: level. Requests pre-emption.
- emerg_phase  in  PW: phase to pre-empt to. Sampled while emerg_req is high. Values ≥ NUM_PHASES are treated as 0.
- flash_mode  in  1: level. Requests flashing mode.
- lights  out  3*NUM_PHASES: phase i lamps at [3i+2:3i] = {red, yellow, green}.
- ped_walk  out  NUM_PHASES: walk indication per phase.
- phase_idx  out  PW: current or last-served phase.
- state  out  3: ALL_RED=0, GREEN=1, YELLOW=2, FLASH=3, PREEMPT=4.

## Operation
- The counter is loaded with D-1 on state entry and decrements each cycle. The state lasts exactly D cycles; the transition occurs on the cycle the counter reads 0.
- ALL_RED: all triplets are 100. On expiry the next state is chosen in this priority order:
  - preempt pending → PREEMPT, with phase_idx=emerg_phase;
  - flash_mode → FLASH;
  - otherwise → GREEN, with phase_idx = phase_idx+1 (mod NUM_PHASES).
- GREEN: the phase_idx triplet is 001; all others are 100.
  - If ped_pend[phase_idx] is set on entry, the duration is GREEN_CYCLES+PED_EXTRA_CYCLES and ped_walk[phase_idx]=1 for the whole green. Otherwise the duration is GREEN_CYCLES.
  - On expiry → YELLOW.
- YELLOW: the phase_idx triplet is 010; others are 100. On expiry → ALL_RED.
- Pedestrian latch:
  - ped_req[i] sets sticky ped_pend[i].
  - ped_pend[i] clears on GREEN entry for phase i.
  - A ped_req[i] in that same cycle wins, so ped_pend[i] stays set for the next service.
- Emergency (emerg_req high, state ≠ FLASH):
  - GREEN with phase_idx == emerg_phase → PREEMPT next cycle. The green stays on without a gap and ped_walk drops.
  - GREEN with phase_idx ≠ emerg_phase → YELLOW next cycle (full YELLOW_CYCLES), with preempt pending set.
  - YELLOW or ALL_RED → the interval completes normally, with preempt pending set.
  - emerg_req dropping before PREEMPT is reached clears preempt pending.
- PREEMPT: emerg_phase is latched into phase_idx on entry. That triplet is 001 and others are 100; ped_walk is all 0. The state holds while emerg_req=1. When emerg_req=0 → YELLOW, then ALL_RED, then normal rotation resumes at phase_idx+1.
- FLASH:
  - Red lamps of all phases are on for FLASH_CYCLES cycles, then off for FLASH_CYCLES cycles, repeating. The first half-period is on.
  - Yellow and green are 0; ped_walk is 0. emerg_req is ignored.
  - When flash_mode=0 → ALL_RED (full duration), then GREEN of phase_idx+1.
- flash_mode during GREEN or YELLOW does not shorten the interval. It is acted on at ALL_RED expiry.

## Timing
- All outputs are registered and update on the rising clk edge after the state change.
- Reset values (asynchronous) are held while reset_n=0:
  - state=ALL_RED, counter=ALL_RED_CYCLES-1, phase_idx=NUM_PHASES-1;
  - lights all triplets 100;
  - ped_walk=0, ped_pend=0, preempt pending=0, flash toggle=on.
- The first GREEN is phase 0, ALL_RED_CYCLES cycles after reset release.
- Asserting reset_n mid-interval aborts immediately to the reset state. Latched requests are lost.
- Input latency: ped_req, emerg_req and flash_mode are sampled at each rising edge and act one cycle later.
- With defaults and no requests, the full rotation period is 2×(20+4+2) = 52 cycles.

## Test plan
- Reset and rotation (defaults):
  - release reset_n → ALL_RED 2 cycles;
  - lights=100_001 (phase 0 green) for 20 cycles;
  - 100_010 for 4 cycles; all-red for 2 cycles;
  - 001_100 (phase 1 green) for 20 cycles;
  - period is 52 cycles.
- Pedestrian: pulse ped_req[1] during phase 0 green → phase 1 green lasts 28 cycles with ped_walk=2'b10 throughout. The next phase 1 green (no new request) lasts 20 cycles.
- Emergency:
  - emerg_req=1 with emerg_phase=1 at cycle 5 of phase 0 green → phase 0 yellow 4 cycles, ALL_RED 2 cycles, then PREEMPT with phase 1 green held.
  - Drop emerg_req → yellow 4, all-red 2, then phase 0 green.
  - emerg_phase equal to the current green phase → state=PREEMPT next cycle with no yellow.
- Flash: flash_mode=1 mid-green → green and yellow complete, then FLASH with reds toggling 5 on / 5 off. emerg_req is ignored. Drop flash_mode → ALL_RED 2 cycles, then the next phase green.
- Reset mid-operation: drop reset_n during YELLOW → lights go all red and state=0 asynchronously, without waiting for a clk edge. On release, phase 0 is green after 2 cycles.
- NUM_PHASES=3, GREEN_CYCLES=3, YELLOW_CYCLES=1, ALL_RED_CYCLES=1: phases 0→1→2→0. Period is 15 cycles. emerg_phase=3 maps to phase 0.
